// File: rtl/fa_bist_ctrl.sv
// Exhaustive BIST controller for a single-bit full adder: walks all eight input
// vectors, compares the adder outputs against the reference and reports the result.
module fa_bist_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_sum,
  input  logic       dut_carry,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic       fail_valid,
  output logic [2:0] first_fail_vec
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [3:0] SettleLast = 4'(SETTLE);

  state_e     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] err_q, err_d;
  logic       fv_q, fv_d;
  logic [2:0] ffv_q, ffv_d;
  logic       pass_q, pass_d;

  logic exp_sum, exp_carry, sample, mismatch;

  always_comb begin
    exp_sum   = ^vec_q;
    exp_carry = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);
    // The sampling edge for a vector is also the edge that advances to the next one.
    sample    = (state_q == StRun) && (cnt_q == SettleLast);
    mismatch  = sample && ((dut_sum != exp_sum) || (dut_carry != exp_carry));

    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ffv_d   = ffv_q;
    pass_d  = pass_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          vec_d   = 3'd0;
          cnt_d   = 4'd0;
          err_d   = 4'd0;
          fv_d    = 1'b0;
          ffv_d   = 3'd0;
          pass_d  = 1'b0;
        end
      end
      StRun: begin
        if (sample) begin
          cnt_d = 4'd0;
          if (mismatch) begin
            err_d = (err_q == 4'd8) ? err_q : err_q + 4'd1;
            if (!fv_q) begin
              fv_d  = 1'b1;
              ffv_d = vec_q;
            end
          end
          if (vec_q == 3'd7) begin
            state_d = StDone;
            pass_d  = (err_d == 4'd0);
          end else begin
            vec_d = vec_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      vec_q   <= 3'd0;
      cnt_q   <= 4'd0;
      err_q   <= 4'd0;
      fv_q    <= 1'b0;
      ffv_q   <= 3'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ffv_q   <= ffv_d;
      pass_q  <= pass_d;
    end
  end

  assign {a, b, c}      = vec_q;
  assign busy           = (state_q == StRun);
  assign done           = (state_q == StDone);
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign fail_valid     = fv_q;
  assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_fa_bist_ctrl.sv
// Bench for fa_bist_ctrl: two instances (SETTLE=2 and SETTLE=0) loop back onto a
// behavioural full adder with selectable faults; results are checked via a scoreboard.
module tb_fa_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start2 = 1'b0, start0 = 1'b0;
  int   fmode = 0;  // 0 golden, 1 sum stuck at 0, 2 carry inverted

  logic       a2, b2, c2, busy2, done2, pass2, fv2, sum2, carry2;
  logic [3:0] err2;
  logic [2:0] ffv2;
  logic       a0, b0, c0, busy0, done0, pass0, fv0, sum0, carry0;
  logic [3:0] err0;
  logic [2:0] ffv0;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] err;
    logic       fv;
    logic [2:0] ffv;
    logic       pass;
  } exp_t;

  exp_t       res_q[$];
  logic [2:0] abc_q[$];

  always #5 clk = ~clk;

  function automatic logic fa_sum(input logic x, y, z, input int fm);
    return (fm == 1) ? 1'b0 : (x ^ y ^ z);
  endfunction

  function automatic logic fa_carry(input logic x, y, z, input int fm);
    logic cy;
    cy = (x & y) | (x & z) | (y & z);
    return (fm == 2) ? ~cy : cy;
  endfunction

  assign sum2   = fa_sum(a2, b2, c2, fmode);
  assign carry2 = fa_carry(a2, b2, c2, fmode);
  assign sum0   = fa_sum(a0, b0, c0, fmode);
  assign carry0 = fa_carry(a0, b0, c0, fmode);

  fa_bist_ctrl #(.SETTLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .dut_sum(sum2), .dut_carry(carry2),
    .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .fail_valid(fv2), .first_fail_vec(ffv2)
  );

  fa_bist_ctrl #(.SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .dut_sum(sum0), .dut_carry(carry0),
    .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .fail_valid(fv0), .first_fail_vec(ffv0)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {a,b,c,busy,done,pass,err_cnt,fail_valid,first_fail_vec}
  function automatic logic [13:0] obs(input bit sel0);
    if (sel0) return {a0, b0, c0, busy0, done0, pass0, err0, fv0, ffv0};
    return {a2, b2, c2, busy2, done2, pass2, err2, fv2, ffv2};
  endfunction

  task automatic set_start(input bit sel0, input logic v);
    if (sel0) start0 = v;
    else start2 = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one pass; hold keeps start high afterwards, repulse pokes start at vector 011.
  task automatic run_pass(input bit sel0, input int fm, input bit repulse, input bit hold);
    int   settle, n;
    exp_t e;
    logic [13:0] o;
    settle = sel0 ? 0 : 2;
    n      = 8 * (settle + 1);
    fmode  = fm;
    e      = '0;
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      logic       es, ec;
      vv = 3'(v);
      es = vv[2] ^ vv[1] ^ vv[0];
      ec = (vv[2] & vv[1]) | (vv[2] & vv[0]) | (vv[1] & vv[0]);
      for (int s = 0; s <= settle; s++) abc_q.push_back(vv);
      if (fa_sum(vv[2], vv[1], vv[0], fm) != es || fa_carry(vv[2], vv[1], vv[0], fm) != ec) begin
        if (!e.fv) e.ffv = vv;
        e.fv  = 1'b1;
        e.err = e.err + 4'd1;
      end
    end
    e.pass = (e.err == 4'd0);
    res_q.push_back(e);

    set_start(sel0, 1'b1);
    step();
    if (!hold) set_start(sel0, 1'b0);
    for (int j = 0; j < n; j++) begin
      o = obs(sel0);
      check_eq("abc_seq", {29'd0, o[13:11]}, {29'd0, abc_q.pop_front()});
      check_eq("busy_run", {31'd0, o[10]}, 32'd1);
      check_eq("done_run", {31'd0, o[9]}, 32'd0);
      if (repulse && j == 3 * (settle + 1)) set_start(sel0, 1'b1);
      if (repulse && j == 3 * (settle + 1) + 1) set_start(sel0, 1'b0);
      step();
    end
    o = obs(sel0);
    e = res_q.pop_front();
    check_eq("done_set", {31'd0, o[9]}, 32'd1);
    check_eq("busy_clr", {31'd0, o[10]}, 32'd0);
    check_eq("abc_hold", {29'd0, o[13:11]}, 32'd7);
    check_eq("pass", {31'd0, o[8]}, {31'd0, e.pass});
    check_eq("err_cnt", {28'd0, o[7:4]}, {28'd0, e.err});
    check_eq("fail_valid", {31'd0, o[3]}, {31'd0, e.fv});
    if (e.fv) check_eq("first_fail_vec", {29'd0, o[2:0]}, {29'd0, e.ffv});
  endtask

  initial begin
    logic [13:0] o;
    #2;
    check_eq("rst_state2", {18'd0, obs(1'b0)}, 32'd0);
    check_eq("rst_state0", {18'd0, obs(1'b1)}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_eq("idle_after_rst", {18'd0, obs(1'b0)}, 32'd0);

    run_pass(1'b0, 0, 1'b0, 1'b0);  // golden, SETTLE=2
    for (int i = 0; i < 3; i++) step();
    check_eq("done_hold", {31'd0, done2}, 32'd1);
    run_pass(1'b0, 1, 1'b0, 1'b0);  // sum stuck at 0
    run_pass(1'b0, 2, 1'b0, 1'b0);  // carry inverted
    run_pass(1'b1, 0, 1'b0, 1'b0);  // golden, SETTLE=0
    run_pass(1'b1, 2, 1'b0, 1'b0);
    run_pass(1'b0, 1, 1'b1, 1'b0);  // start re-pulsed mid-run

    // Back-to-back: start held high restarts on the first edge in DONE.
    run_pass(1'b0, 0, 1'b0, 1'b1);
    step();
    check_eq("b2b_busy", {31'd0, busy2}, 32'd1);
    check_eq("b2b_done", {31'd0, done2}, 32'd0);
    check_eq("b2b_abc", {29'd0, a2, b2, c2}, 32'd0);
    check_eq("b2b_err", {28'd0, err2}, 32'd0);
    start2 = 1'b0;
    for (int i = 0; i < 30; i++) step();
    check_eq("b2b_finish", {30'd0, done2, pass2}, 32'd3);

    // Asynchronous reset mid-pass at vector 101, then a clean pass.
    fmode  = 1;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int j = 0; j < 15; j++) step();
    check_eq("abc_before_rst", {29'd0, a2, b2, c2}, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    o = obs(1'b0);
    check_eq("async_rst", {18'd0, o}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check_eq("idle_no_start", {30'd0, busy2, done2}, 32'd0);
    run_pass(1'b0, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fa_bist_ctrl.md
FA_BIST_CTRL -- requirements
Module: fa_bist_ctrl

Interface
REQ-001 Parameter: SETTLE, default 2, number of extra clock cycles each test vector is held before its result is sampled; legal range 0..15.
REQ-002 clk  input  1  sole clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to run one exhaustive test pass; level sampled on the rising edge of clk.
REQ-005 dut_sum  input  1  sum output returned by the full-adder under test.
REQ-006 dut_carry  input  1  carry output returned by the full-adder under test.
REQ-007 a, b, c  output  1 each  registered stimulus bits driven to the full-adder under test.
REQ-008 busy  output  1  high while a test pass is running.
REQ-009 done  output  1  high once a pass completes; held until the next start or reset.
REQ-010 pass  output  1  valid only while done=1; high when err_cnt=0.
REQ-011 err_cnt  output  4  number of mismatching vectors in the current or last pass, range 0..8.
REQ-012 fail_valid  output  1  high once at least one mismatch has occurred in the current or last pass.
REQ-013 first_fail_vec  output  3  {a,b,c} of the first mismatching vector; meaningful only when fail_valid=1.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE or DONE, start=1 at edge k SHALL do all of the following:
- load vector index v=0 and drive {a,b,c}=000;
- clear err_cnt, fail_valid and first_fail_vec;
- clear done and pass, set busy, and enter RUN.
REQ-016 In RUN, each vector v (0..7) SHALL be driven on {a,b,c}={v[2],v[1],v[0]} for exactly SETTLE+1 cycles.
REQ-017 Vectors SHALL be applied in ascending order 000, 001, ..., 111, with no gap cycles between them.
REQ-018 dut_sum and dut_carry for vector v SHALL be sampled at edge k+(v+1)*(SETTLE+1), the same edge that advances {a,b,c} to v+1.
REQ-019 Expected values for a sampled vector SHALL be: sum=a^b^c; carry=(a&b)|(a&c)|(b&c).
REQ-020 A mismatch on sum, carry or both SHALL increment err_cnt by exactly 1 for that vector.
REQ-021 On the first mismatch of a pass, first_fail_vec SHALL capture the failing vector and fail_valid SHALL set; later mismatches SHALL leave first_fail_vec unchanged.
REQ-022 At edge k+8*(SETTLE+1), after vector 111 is sampled, the block SHALL do all of the following:
- enter DONE;
- clear busy and set done;
- set pass=(err_cnt==0), with err_cnt including the result of vector 111.
REQ-023 In DONE, {a,b,c} SHALL hold 111, and all result outputs SHALL hold until the next accepted start or reset.
REQ-024 start asserted while in RUN SHALL be ignored, with no restart and no effect on counters.
REQ-025 start held high continuously SHALL start a new pass on the first edge in DONE; this is the intended back-to-back mode.
REQ-026 err_cnt SHALL NOT wrap; its maximum value is 8.
REQ-027 dut_sum and dut_carry SHALL be treated as synchronous to clk; no synchronizer SHALL be included.

Reset
REQ-028 While rst_n=0, the block SHALL hold:
- state=IDLE;
- a=b=c=0, v=0;
- busy=0, done=0, pass=0;
- err_cnt=0, fail_valid=0, first_fail_vec=000.
REQ-029 Reset asserted mid-pass SHALL abort the pass immediately without waiting for a clock edge.
REQ-030 After rst_n deasserts, the block SHALL remain in IDLE until start is sampled high.

Verification
REQ-031 Golden loopback (DUT = correct full adder, SETTLE=2), start pulsed at edge k -> busy high for 24 cycles, done=1 at edge k+24, pass=1, err_cnt=0, fail_valid=0.
REQ-032 dut_sum stuck at 0, carry correct -> err_cnt=4 (vectors 001, 010, 100, 111), first_fail_vec=001, fail_valid=1, pass=0.
REQ-033 dut_carry inverted, sum correct -> err_cnt=8, first_fail_vec=000, pass=0.
REQ-034 SETTLE=0, golden DUT -> each vector held 1 cycle, done at edge k+8, pass=1; check {a,b,c} sequence 000..111 cycle by cycle.
REQ-035 start re-pulsed at vector 011 during RUN -> ignored, and done still occurs at edge k+8*(SETTLE+1) from the original start.
REQ-036 rst_n low mid-pass at vector 101 -> all outputs return to reset values immediately; a following start runs a full clean pass with pass=1.
